// File: rtl/mult_share_arbiter_pkg.sv
// rtl/mult_share_arbiter_pkg.sv - shared state encoding and helpers for the multiplier-sharing arbiter
package mult_share_arbiter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_PIPE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester operand and result bus of the multiplier-sharing arbiter
interface mult_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [2*WIDTH-1:0]     res_product;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_id, res_product
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_id, res_product
    );
endinterface

// File: rtl/mult_share_arbiter_rr_pick.sv
// rtl/mult_share_arbiter_rr_pick.sv - combinational round-robin picker (first request at or above ptr, wrapping)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && (((req >> cand) & N_REQ'(1)) != '0)) begin
                any   = 1'b1;
                idx   = ID_W'(cand);
                grant = N_REQ'(1) << cand;
            end
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sequencer for one shared array multiplier; MULT_SHARE_PIPE_EN adds a second settle cycle
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_share_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_p
);

`ifdef MULT_SHARE_PIPE_EN
    localparam state_t CAPTURE_ST = ST_PIPE;
`else
    localparam state_t CAPTURE_ST = ST_CALC;
`endif

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, cur_id, pick_idx;
    logic [N_REQ-1:0]   pick_grant;
    logic               pick_any, accept;
    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [2*WIDTH-1:0] res_product_q;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign accept          = (state == ST_IDLE) && !reset && pick_any;
    assign bus.req_ready   = accept ? pick_grant : '0;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_id      = res_id_q;
    assign bus.res_product = res_product_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_any) state_nxt = ST_CALC;
`ifdef MULT_SHARE_PIPE_EN
            ST_CALC: state_nxt = ST_PIPE;
            ST_PIPE: state_nxt = ST_DONE;
`else
            ST_CALC: state_nxt = ST_DONE;
            ST_PIPE: state_nxt = ST_IDLE;
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            cur_id        <= '0;
            mult_a        <= '0;
            mult_b        <= '0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_product_q <= '0;
        end else begin
            state       <= state_nxt;
            // res_valid rises in the cycle after the capture edge, i.e. while in DONE
            res_valid_q <= (state == CAPTURE_ST);
            if (accept) begin
                mult_a <= bus.req_a[int'(pick_idx)*WIDTH +: WIDTH];
                mult_b <= bus.req_b[int'(pick_idx)*WIDTH +: WIDTH];
                cur_id <= pick_idx;
                rr_ptr <= ID_W'(next_ptr(int'(pick_idx), N_REQ));
            end
            if (state == CAPTURE_ST) begin
                res_product_q <= mult_p;
                res_id_q      <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - randomized bench with behavioural reference model for mult_share_arbiter
module tb_mult_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
`ifdef MULT_SHARE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();
    logic [W-1:0]   mult_a, mult_b;
    logic [2*W-1:0] mult_p;
    assign mult_p = mult_a * mult_b;

    mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .mult_a (mult_a),
        .mult_b (mult_b),
        .mult_p (mult_p)
    );

    logic [N-1:0] v;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic [N*W-1:0] a_flat, b_flat;
    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int i = 0; i < N; i++) begin
            a_flat[i*W +: W] = a[i];
            b_flat[i*W +: W] = b[i];
        end
    end
    assign bus.req_valid = v;
    assign bus.req_a     = a_flat;
    assign bus.req_b     = b_flat;

    int total = 0, bad = 0, cyc = 0;
    // model: pointer, first cycle the arbiter is free, one pending result
    int ptr, free_cyc, acc_now;
    bit pend;
    int pend_cyc, pend_id, pend_prod, last_id, last_prod;
    int acc_id_q[$], acc_cyc_q[$], res_id_q[$], res_prod_q[$], res_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic eval();
        int w;
        logic [N-1:0] exp_rdy;
        bit exp_rv;
        w = -1;
        exp_rdy = '0;
        if (!reset && cyc >= free_cyc)
            for (int k = 0; k < N; k++)
                if (w < 0 && v[(ptr + k) % N]) w = (ptr + k) % N;
        if (w >= 0) exp_rdy[w] = 1'b1;
        exp_rv = pend && (pend_cyc == cyc);
        if (exp_rv) begin
            last_id = pend_id;
            last_prod = pend_prod;
            pend = 0;
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("res_valid", 64'(bus.res_valid), 64'(exp_rv));
        check("res_id", 64'(bus.res_id), 64'(last_id));
        check("res_product", 64'(bus.res_product), 64'(last_prod));
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i] && v[i]) begin
                acc_id_q.push_back(i);
                acc_cyc_q.push_back(cyc);
            end
        if (bus.res_valid === 1'b1) begin
            res_id_q.push_back(int'(bus.res_id));
            res_prod_q.push_back(int'(bus.res_product));
            res_cyc_q.push_back(cyc);
        end
        acc_now = -1;
        if (reset) begin
            ptr = 0; pend = 0; last_id = 0; last_prod = 0; free_cyc = cyc + 1;
        end else if (w >= 0) begin
            acc_now = w;
            pend = 1; pend_cyc = cyc + LAT; pend_id = w;
            pend_prod = int'(a[w]) * int'(b[w]);
            ptr = (w + 1) % N;
            free_cyc = cyc + LAT + 1;
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom % 4)
            0: return '0;
            1: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run(input int n, input bit rnd);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            eval();
            @(posedge clk);
            #1;
            cyc++;
            if (acc_now >= 0) begin
                v[acc_now] = rnd ? 1'($urandom % 2) : 1'b0;
                a[acc_now] = rand_op();
                b[acc_now] = rand_op();
            end
            if (rnd) begin
                for (int i = 0; i < N; i++)
                    if (i != acc_now) begin
                        if (!v[i] && ($urandom % 2 == 0)) begin
                            v[i] = 1'b1; a[i] = rand_op(); b[i] = rand_op();
                        end else if (v[i] && ($urandom % 8 == 0)) v[i] = 1'b0;
                    end
                reset = ($urandom % 64 == 0);
            end
        end
    endtask

    task automatic clearq();
        acc_id_q.delete(); acc_cyc_q.delete();
        res_id_q.delete(); res_prod_q.delete(); res_cyc_q.delete();
    endtask

    task automatic reset_pulse();
        v = '0;
        reset = 1'b1;
        run(2, 1'b0);
        reset = 1'b0;
        clearq();
    endtask

    initial begin
        reset = 1'b1;
        v = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; end
        @(posedge clk);
        #1;
        ptr = 0; free_cyc = 0; pend = 0; last_id = 0; last_prod = 0; acc_now = -1;
        reset_pulse();

        // single requester, latency
        v = 4'b0001; a[0] = 8'd12; b[0] = 8'd10;
        run(8, 1'b0);
        check("t1_id", 64'(qget(res_id_q, 0)), 64'd0);
        check("t1_product", 64'(qget(res_prod_q, 0)), 64'd120);
        check("t1_latency", 64'(qget(res_cyc_q, 0) - qget(acc_cyc_q, 0)), 64'(LAT));

        // all four valid: grants 0..3
        reset_pulse();
        v = 4'b1111;
        for (int i = 0; i < N; i++) begin a[i] = W'(i + 1); b[i] = 8'd3; end
        run(20, 1'b0);
        for (int i = 0; i < N; i++) begin
            check("t2_grant", 64'(qget(acc_id_q, i)), 64'(i));
            check("t2_product", 64'(qget(res_prod_q, i)), 64'(3 * (i + 1)));
        end
        check("t2_spacing", 64'(qget(acc_cyc_q, 1) - qget(acc_cyc_q, 0)), 64'(LAT + 1));

        // wrap after requester 3, extremes
        clearq();
        v = 4'b1001; a[0] = 8'd255; b[0] = 8'd255; a[3] = 8'd0; b[3] = 8'd200;
        run(12, 1'b0);
        check("t3_grant0", 64'(qget(acc_id_q, 0)), 64'd0);
        check("t3_grant1", 64'(qget(acc_id_q, 1)), 64'd3);
        check("t3_max", 64'(qget(res_prod_q, 0)), 64'd65025);
        check("t3_zero", 64'(qget(res_prod_q, 1)), 64'd0);

        // reset during CALC aborts the product and resets the pointer
        reset_pulse();
        v = 4'b0010; a[1] = 8'd5; b[1] = 8'd5;
        run(1, 1'b0);
        reset = 1'b1;
        run(1, 1'b0);
        reset = 1'b0;
        run(6, 1'b0);
        check("t5_accepts", 64'(acc_id_q.size()), 64'd1);
        check("t5_no_result", 64'(res_id_q.size()), 64'd0);
        clearq();
        v = 4'b0110; a[1] = 8'd2; b[1] = 8'd3; a[2] = 8'd4; b[2] = 8'd5;
        run(12, 1'b0);
        check("t5_grant0", 64'(qget(acc_id_q, 0)), 64'd1);
        check("t5_grant1", 64'(qget(acc_id_q, 1)), 64'd2);
        check("t5_prod1", 64'(qget(res_prod_q, 1)), 64'd20);

        // requester 2 withdraws while 1 is served
        reset_pulse();
        v = 4'b0110; a[1] = 8'd3; b[1] = 8'd7; a[2] = 8'd9; b[2] = 8'd9;
        run(1, 1'b0);
        v[2] = 1'b0;
        run(8, 1'b0);
        check("t6_accepts", 64'(acc_id_q.size()), 64'd1);
        check("t6_id", 64'(qget(res_id_q, 0)), 64'd1);
        check("t6_product", 64'(qget(res_prod_q, 0)), 64'd21);

        // randomized traffic with occasional resets
        reset_pulse();
        run(3000, 1'b1);
        reset = 1'b0;
        run(8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
